// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB stepping,
// memory handshake with timeout, flags, branch resolve, retire count.
module multi_cycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             cls_mem,
  input  logic             cls_store,
  input  logic             cls_branch,
  input  logic             uncond_br,
  input  logic [1:0]       cond_sel,
  input  logic             set_flag,
  input  logic             halt,
  input  logic [3:0]       alu_flags,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_en,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             timeout_err
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_retired;
  logic [WW-1:0]    r_wait;

  logic w_cond;
  logic w_last;
  logic w_imem_req;
  logic w_ir_load;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_reg_we;
  logic w_pc_en;
  logic w_br_taken;
  logic w_halted;
  logic w_terr;

  // flags are {C,V,Z,N}; CBZ tests the live ALU zero
  always_comb begin
    w_cond = 1'b0;
    case (cond_sel)
      2'b00:   w_cond = alu_flags[1];
      2'b01:   w_cond = r_flags[1];
      2'b10:   w_cond = r_flags[0] ^ r_flags[2];
      default: w_cond = ~r_flags[1];
    endcase
  end

  assign w_last = (r_wait == LAST);

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_load  = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_reg_we   = 1'b0;
    w_pc_en    = 1'b0;
    w_br_taken = 1'b0;
    w_halted   = 1'b0;
    w_terr     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (w_last) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: w_next = halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (cls_branch) begin
          w_pc_en    = 1'b1;
          w_br_taken = uncond_br | w_cond;
          w_next     = S_FETCH;
        end else if (cls_mem) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = cls_store;
        if (dmem_ready) begin
          w_pc_en = cls_store;
          w_next  = cls_store ? S_FETCH : S_WB;
        end else if (w_last) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_en  = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_halted = 1'b1;
      S_ERR:   w_terr   = 1'b1;
      default: w_next   = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_flags   <= '0;
      r_retired <= '0;
      r_wait    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC && set_flag)
        r_flags <= alu_flags;
      if (w_pc_en)
        r_retired <= r_retired + 1'b1;
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + 1'b1;
    end
  end

  assign state       = reset ? 3'd0 : r_state;
  assign imem_req    = w_imem_req & ~reset;
  assign ir_load     = w_ir_load  & ~reset;
  assign dmem_req    = w_dmem_req & ~reset;
  assign dmem_we     = w_dmem_we  & ~reset;
  assign reg_we      = w_reg_we   & ~reset;
  assign pc_en       = w_pc_en    & ~reset;
  assign br_taken    = w_br_taken & ~reset;
  assign flags       = reset ? 4'd0 : r_flags;
  assign retired     = reset ? '0 : r_retired;
  assign halted      = w_halted   & ~reset;
  assign timeout_err = w_terr     & ~reset;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Scoreboard bench for multi_cycle_sequencer: instruction-level
// reference model, latency-programmable memory responders.
module tb_multi_cycle_sequencer;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic cls_mem = 0, cls_store = 0, cls_branch = 0, uncond_br = 0;
  logic [1:0] cond_sel = 0;
  logic set_flag = 0, halt = 0;
  logic [3:0] alu_flags = 0;
  logic [2:0] state;
  logic imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_en, br_taken;
  logic [3:0] flags;
  logic [CNT_W-1:0] retired;
  logic halted, timeout_err;

  always #5 clk = ~clk;

  multi_cycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .cls_mem(cls_mem), .cls_store(cls_store),
    .cls_branch(cls_branch), .uncond_br(uncond_br),
    .cond_sel(cond_sel), .set_flag(set_flag), .halt(halt),
    .alu_flags(alu_flags), .state(state),
    .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_en(pc_en), .br_taken(br_taken),
    .flags(flags), .retired(retired),
    .halted(halted), .timeout_err(timeout_err)
  );

  typedef struct {
    bit         taken;
    bit         rwe;
    bit         dwe;
    int         lat;
    logic [3:0] fl;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int errors = 0;
  int iw = 0, dw = 0;
  logic [3:0]  m_flags = 0;
  logic [31:0] m_ret = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // memories answer after iw / dw wait cycles of a request
  initial begin
    int ic, dc;
    ic = 0; dc = 0;
    forever begin
      @(posedge clk); #2;
      if (!imem_req) begin ic = 0; imem_ready = 0; end
      else begin imem_ready = (ic == iw); ic++; end
      if (!dmem_req) begin dc = 0; dmem_ready = 0; end
      else begin dmem_ready = (dc == dw); dc++; end
    end
  end

  // monitor: pops on every pc_en, checks state one cycle later
  initial begin
    int cyc;
    bit pend;
    exp_t e, pe;
    cyc = 0; pend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; pend = 0; q.delete();
        continue;
      end
      cyc++;
      if (pend) begin
        chk("flags", flags, pe.fl);
        chk("retired", retired, pe.ret);
        pend = 0;
      end
      if (reg_we && !pc_en) chk("stray_reg_we", reg_we, 0);
      if (pc_en) begin
        if (q.size() == 0) begin
          chk("unexpected_pc_en", pc_en, 0);
        end else begin
          e = q.pop_front();
          chk("br_taken", br_taken, e.taken);
          chk("reg_we", reg_we, e.rwe);
          chk("dmem_we", dmem_we, e.dwe);
          chk("latency", cyc, e.lat);
          pe = e; pend = 1;
        end
        cyc = 0;
      end
    end
  end

  task automatic set_in(input int k, input logic [3:0] af,
                        input bit sf, input logic [1:0] cs,
                        input bit ub, input int iwv, input int dwv);
    cls_branch = (k == K_BR);
    cls_mem    = (k == K_LD) || (k == K_ST);
    cls_store  = (k == K_ST);
    halt = 0; alu_flags = af; set_flag = sf;
    cond_sel = cs; uncond_br = ub; iw = iwv; dw = dwv;
  endtask

  task automatic issue(input int k, input logic [3:0] af,
                       input bit sf, input logic [1:0] cs,
                       input bit ub, input int iwv, input int dwv);
    exp_t e;
    bit c, z, n, v;
    int t;
    set_in(k, af, sf, cs, ub, iwv, dwv);
    z = m_flags[1]; n = m_flags[0]; v = m_flags[2];
    case (cs)
      2'd0: c = af[1];
      2'd1: c = z;
      2'd2: c = n ^ v;
      default: c = !z;
    endcase
    e.taken = (k == K_BR) && (ub || c);
    e.rwe = (k == K_ALU) || (k == K_LD);
    e.dwe = (k == K_ST);
    case (k)
      K_ALU: e.lat = 4 + iwv;
      K_BR:  e.lat = 3 + iwv;
      K_ST:  e.lat = 4 + iwv + dwv;
      default: e.lat = 5 + iwv + dwv;
    endcase
    if (sf) m_flags = af;
    m_ret++;
    e.fl = m_flags; e.ret = m_ret;
    q.push_back(e);
    t = 0;
    do begin @(negedge clk); t++; end
    while (!pc_en && t < 200);
    if (!pc_en) chk("instr_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    m_flags = 0; m_ret = 0;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_flags", flags, 0);
    chk("rst_retired", retired, 0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    do_reset();
    issue(K_ALU, 4'b0010, 1, 0, 0, 0, 0);
    issue(K_LD,  4'b0000, 0, 0, 0, 0, 3);
    issue(K_ST,  4'b0000, 0, 0, 0, 0, 0);
    issue(K_BR,  4'b0000, 1, 1, 0, 0, 0);
    issue(K_BR,  4'b0000, 0, 3, 0, 0, 0);
    issue(K_BR,  4'b0010, 0, 0, 0, 0, 0);
    issue(K_BR,  4'b0000, 0, 0, 0, 0, 0);
    issue(K_ALU, 4'b0101, 1, 0, 0, 1, 0);
    issue(K_BR,  4'b0000, 0, 2, 0, 0, 0);
    issue(K_ALU, 4'b0001, 1, 0, 0, 0, 0);
    issue(K_BR,  4'b0000, 0, 2, 0, 2, 0);
    issue(K_BR,  4'b0000, 0, 1, 1, 0, 0);
    issue(K_ALU, 4'b1000, 1, 0, 0, TIMEOUT - 1, 0);
    issue(K_LD,  4'b0100, 1, 0, 0, 0, TIMEOUT - 1);
    repeat (150)
      issue($urandom_range(0, 3), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
            $urandom_range(0, 3));

    // reset while a load waits in MEM
    set_in(K_LD, 4'b1111, 1, 0, 0, 0, 10);
    t = 0;
    do begin @(negedge clk); t++; end
    while (state != 3'd3 && t < 20);
    repeat (3) @(negedge clk);
    chk("mem_wait_req", dmem_req, 1);
    do_reset();
    issue(K_ALU, 4'b0011, 1, 0, 0, 0, 0);

    // halt is sticky and retires nothing
    set_in(K_ALU, 4'b0000, 0, 0, 0, 0, 0);
    halt = 1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!halted && t < 20);
    chk("halt_state", state, 5);
    repeat (4) begin
      @(negedge clk);
      chk("halt_sticky", halted, 1);
      chk("halt_pc_en", pc_en, 0);
      chk("halt_imem_req", imem_req, 0);
      chk("halt_retired", retired, m_ret);
    end
    do_reset();

    // fetch never answered: ERR after TIMEOUT wait cycles
    set_in(K_ALU, 4'b0000, 0, 0, 0, TIMEOUT + 4, 0);
    repeat (TIMEOUT) @(negedge clk);
    chk("pre_err_state", state, 0);
    @(negedge clk);
    chk("err_state", state, 6);
    chk("err_flag", timeout_err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", timeout_err, 1);
    chk("err_imem_req", imem_req, 0);
    do_reset();
    issue(K_ST, 4'b0000, 0, 0, 0, 1, 2);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
